cpu_ad48_irq_ctrl: RTL and testbench

External interrupt controller directly upstream of the cpu_ad48 `irq` input.
- Synchronises NUM_SRC asynchronous device interrupt sources.
- Applies per-source polarity, edge/level mode and enable, and latches pending state.
- Routes each source to one of IRQ_LINES CPU lines and drives them as levels.
- Software configures it and claims/clears sources through a simple word-addressed register port on the 48-bit data side.

---
 rtl/cpu_ad48_irq_ctrl_pkg.sv | 16 +
 rtl/cpu_ad48_irq_sync.sv | 42 ++++
 rtl/cpu_ad48_irq_ctrl.sv | 145 ++++++++++++++
 tb/tb_cpu_ad48_irq_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_ad48_irq_ctrl_pkg.sv
// rtl/cpu_ad48_irq_ctrl_pkg.sv - shared register map and field constants for the irq controller
package cpu_ad48_irq_ctrl_pkg;

    localparam int DATA_W = 48;

    localparam logic [2:0] IRQC_ADDR_ENABLE   = 3'd0;
    localparam logic [2:0] IRQC_ADDR_MODE     = 3'd1;
    localparam logic [2:0] IRQC_ADDR_PENDING  = 3'd2;
    localparam logic [2:0] IRQC_ADDR_ROUTE    = 3'd3;
    localparam logic [2:0] IRQC_ADDR_CLAIM    = 3'd4;
    localparam logic [2:0] IRQC_ADDR_POLARITY = 3'd5;

    localparam int IRQC_CLAIM_VALID_BIT = 47;
    localparam int IRQC_ROUTE_W         = 2;

endpackage

// File: rtl/cpu_ad48_irq_sync.sv
// rtl/cpu_ad48_irq_sync.sv - per-source synchroniser, polarity correction and edge history
module cpu_ad48_irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic src,
    input  logic polarity,
    input  logic polarity_next,
    input  logic reload,
    output logic active,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    assign active = sync_q[SYNC_STAGES-1] ^ polarity;
    assign rise   = active & ~hist_q;

    // Shift the raw source through the synchroniser chain.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], src};
        end
    end

    // Edge history; on a config change it is seeded with the level seen
    // under the polarity that takes effect, so no false edge appears.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hist_q <= 1'b0;
        end else if (reload) begin
            hist_q <= sync_q[SYNC_STAGES-1] ^ polarity_next;
        end else begin
            hist_q <= active;
        end
    end

endmodule

// File: rtl/cpu_ad48_irq_ctrl.sv
// rtl/cpu_ad48_irq_ctrl.sv - external interrupt controller feeding the cpu_ad48 irq lines
module cpu_ad48_irq_ctrl
    import cpu_ad48_irq_ctrl_pkg::*;
#(
    parameter int NUM_SRC     = 8,
    parameter int IRQ_LINES   = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NUM_SRC-1:0]   src,
    output logic [IRQ_LINES-1:0] irq,
    input  logic                 cfg_we,
    input  logic                 cfg_re,
    input  logic [2:0]           cfg_addr,
    input  logic [DATA_W-1:0]    cfg_wdata,
    output logic [DATA_W-1:0]    cfg_rdata
);

    logic [NUM_SRC-1:0]              enable, mode, polarity, pending;
    logic [IRQC_ROUTE_W*NUM_SRC-1:0] route;
    logic [NUM_SRC-1:0]              active, rise, changed, polarity_next, wsrc;
    logic [63:0]                     wdata_ext, rd_mux;
    logic [IRQ_LINES-1:0]            irq_next;
    logic [NUM_SRC-1:0]              pend_en;
    logic [5:0]                      claim_id;
    logic                            claim_valid;
    logic                            wr_enable, wr_mode, wr_pending, wr_route, wr_polarity;
    logic                            unused_wdata;

    assign wdata_ext    = {16'b0, cfg_wdata};
    assign wsrc         = cfg_wdata[NUM_SRC-1:0];
    assign unused_wdata = ^wdata_ext;

    assign wr_enable   = cfg_we && (cfg_addr == IRQC_ADDR_ENABLE);
    assign wr_mode     = cfg_we && (cfg_addr == IRQC_ADDR_MODE);
    assign wr_pending  = cfg_we && (cfg_addr == IRQC_ADDR_PENDING);
    assign wr_route    = cfg_we && (cfg_addr == IRQC_ADDR_ROUTE);
    assign wr_polarity = cfg_we && (cfg_addr == IRQC_ADDR_POLARITY);

    assign polarity_next = wr_polarity ? wsrc : polarity;
    assign changed       = (wr_mode     ? (wsrc ^ mode)     : '0)
                         | (wr_polarity ? (wsrc ^ polarity) : '0);
    assign pend_en       = pending & enable;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            cpu_ad48_irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
                .clk           (clk),
                .resetn        (resetn),
                .src           (src[gi]),
                .polarity      (polarity[gi]),
                .polarity_next (polarity_next[gi]),
                .reload        (changed[gi]),
                .active        (active[gi]),
                .rise          (rise[gi])
            );
        end
    endgenerate

    // Configuration registers written directly from the register port.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            enable   <= '0;
            mode     <= '0;
            polarity <= '0;
            route    <= '0;
        end else begin
            if (wr_enable)   enable   <= wsrc;
            if (wr_mode)     mode     <= wsrc;
            if (wr_polarity) polarity <= wsrc;
            if (wr_route)    route    <= wdata_ext[IRQC_ROUTE_W*NUM_SRC-1:0];
        end
    end

    // Pending: edge sources latch rises (set beats W1C), level sources track a_i.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (changed[i]) begin
                    pending[i] <= 1'b0;
                end else if (mode[i]) begin
                    if (rise[i]) begin
                        pending[i] <= 1'b1;
                    end else if (wr_pending && wsrc[i]) begin
                        pending[i] <= 1'b0;
                    end
                end else begin
                    pending[i] <= active[i];
                end
            end
        end
    end

    // Route OR-reduction onto the CPU lines and lowest-index claim encoder.
    always_comb begin
        irq_next    = '0;
        claim_id    = '0;
        claim_valid = |pend_en;
        for (int l = 0; l < IRQ_LINES; l++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (pend_en[i] && (route[IRQC_ROUTE_W*i +: IRQC_ROUTE_W] == IRQC_ROUTE_W'(l))) begin
                    irq_next[l] = 1'b1;
                end
            end
        end
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pend_en[i]) begin
                claim_id = 6'(i);
            end
        end
    end

    // Read data multiplexer over the register map.
    always_comb begin
        rd_mux = '0;
        case (cfg_addr)
            IRQC_ADDR_ENABLE:   rd_mux[NUM_SRC-1:0] = enable;
            IRQC_ADDR_MODE:     rd_mux[NUM_SRC-1:0] = mode;
            IRQC_ADDR_PENDING:  rd_mux[NUM_SRC-1:0] = pending;
            IRQC_ADDR_ROUTE:    rd_mux[IRQC_ROUTE_W*NUM_SRC-1:0] = route;
            IRQC_ADDR_CLAIM: begin
                rd_mux[IRQC_CLAIM_VALID_BIT] = claim_valid;
                rd_mux[5:0]                  = claim_id;
            end
            IRQC_ADDR_POLARITY: rd_mux[NUM_SRC-1:0] = polarity;
            default:            rd_mux = '0;
        endcase
    end

    // Registered outputs: irq levels every cycle, read data only on cfg_re.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            irq       <= '0;
            cfg_rdata <= '0;
        end else begin
            irq <= irq_next;
            if (cfg_re) cfg_rdata <= rd_mux[DATA_W-1:0];
        end
    end

endmodule

// File: tb/tb_cpu_ad48_irq_ctrl.sv
// tb/tb_cpu_ad48_irq_ctrl.sv - directed self-checking bench for cpu_ad48_irq_ctrl
module tb_cpu_ad48_irq_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic [7:0]  src;
    logic [3:0]  irq;
    logic        cfg_we, cfg_re;
    logic [2:0]  cfg_addr;
    logic [47:0] cfg_wdata, cfg_rdata;
    logic [47:0] rd;
    int          checks = 0;
    int          failures = 0;

    localparam logic [47:0] VALID = 48'h8000_0000_0000;

    cpu_ad48_irq_ctrl #(.NUM_SRC(8), .IRQ_LINES(4), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .src       (src),
        .irq       (irq),
        .cfg_we    (cfg_we),
        .cfg_re    (cfg_re),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [47:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic rdreg(input logic [2:0] a, output logic [47:0] d);
        cfg_re = 1'b1; cfg_addr = a;
        tick();
        cfg_re = 1'b0;
        d = cfg_rdata;
    endtask

    initial begin
        resetn = 1'b0; src = '0; cfg_we = 1'b0; cfg_re = 1'b0;
        cfg_addr = '0; cfg_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_irq", {44'b0, irq}, 48'h0);
        check("rst_rdata", cfg_rdata, 48'h0);
        resetn = 1'b1;
        tick();

        // 1: reset values, unused bits, read/write collision
        for (int a = 0; a < 8; a++) begin
            rdreg(3'(a), rd);
            check($sformatf("rst_reg%0d", a), rd, 48'h0);
        end
        cfg_re = 1'b1; cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = 48'hFFFF_FFFF_FFFF;
        tick();
        cfg_re = 1'b0; cfg_we = 1'b0;
        check("rw_same_old", cfg_rdata, 48'h0);
        rdreg(3'd0, rd);
        check("enable_mask", rd, 48'hFF);
        wr(3'd6, 48'h1234);
        rdreg(3'd6, rd);
        check("addr6_zero", rd, 48'h0);

        // 2: edge source 0 on line 0
        wr(3'd0, 48'h01);
        wr(3'd1, 48'h01);
        wr(3'd3, 48'h00);
        src[0] = 1'b1;
        tick(); tick();
        src[0] = 1'b0;
        tick();
        check("t2_lat3", {44'b0, irq}, 48'h0);
        tick();
        check("t2_lat4", {44'b0, irq}, 48'h1);
        rdreg(3'd4, rd);
        check("t2_claim", rd, VALID);
        wr(3'd2, 48'h01);
        tick();
        check("t2_w1c_irq", {44'b0, irq}, 48'h0);
        rdreg(3'd4, rd);
        check("t2_claim_none", rd, 48'h0);

        // 3: level source 3, active-low, line 2
        src[3] = 1'b1;
        tick(); tick(); tick();
        wr(3'd5, 48'h08);
        wr(3'd0, 48'h09);
        wr(3'd3, 48'h80);
        tick();
        check("t3_idle", {44'b0, irq}, 48'h0);
        src[3] = 1'b0;
        tick(); tick(); tick();
        check("t3_lat3", {44'b0, irq}, 48'h0);
        tick();
        check("t3_lat4", {44'b0, irq}, 48'h4);
        wr(3'd2, 48'h08);
        rdreg(3'd2, rd);
        check("t3_w1c_noeff", rd, 48'h08);
        check("t3_irq_held", {44'b0, irq}, 48'h4);
        src[3] = 1'b1;
        tick(); tick(); tick();
        check("t3_fall3", {44'b0, irq}, 48'h4);
        tick();
        check("t3_fall4", {44'b0, irq}, 48'h0);

        // 4: sources 2 and 5 on line 1, claim priority
        wr(3'd3, 48'h490);
        wr(3'd1, 48'h25);
        wr(3'd0, 48'h2D);
        src[2] = 1'b1; src[5] = 1'b1;
        tick(); tick();
        src[2] = 1'b0; src[5] = 1'b0;
        tick(); tick();
        check("t4_irq", {44'b0, irq}, 48'h2);
        rdreg(3'd4, rd);
        check("t4_claim2", rd, VALID | 48'd2);
        wr(3'd2, 48'h04);
        rdreg(3'd4, rd);
        check("t4_claim5", rd, VALID | 48'd5);
        check("t4_irq_held", {44'b0, irq}, 48'h2);
        wr(3'd2, 48'h20);
        tick();
        check("t4_irq_clr", {44'b0, irq}, 48'h0);

        // 5: set wins over W1C; MODE toggle produces no spurious edge
        src[0] = 1'b1;
        tick(); tick();
        wr(3'd2, 48'h01);
        rdreg(3'd2, rd);
        check("t5_set_wins", rd, 48'h01);
        wr(3'd1, 48'h24);
        wr(3'd1, 48'h25);
        tick(); tick();
        rdreg(3'd2, rd);
        check("t5_mode_toggle", rd, 48'h00);
        src[0] = 1'b0;
        tick(); tick(); tick();

        // 6: masking retains pending
        src[0] = 1'b1;
        tick(); tick();
        src[0] = 1'b0;
        tick(); tick();
        check("t6_irq", {44'b0, irq}, 48'h1);
        wr(3'd0, 48'h2C);
        tick();
        check("t6_masked_irq", {44'b0, irq}, 48'h0);
        rdreg(3'd4, rd);
        check("t6_masked_claim", rd, 48'h0);
        rdreg(3'd2, rd);
        check("t6_pend_kept", rd, 48'h01);
        wr(3'd0, 48'h2D);
        tick();
        check("t6_reenable", {44'b0, irq}, 48'h1);

        // asynchronous reset while pending
        rdreg(3'd0, rd);
        resetn = 1'b0;
        #1;
        check("async_irq", {44'b0, irq}, 48'h0);
        check("async_rdata", cfg_rdata, 48'h0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        tick();
        rdreg(3'd2, rd);
        check("post_rst_pend", rd, 48'h0);
        rdreg(3'd0, rd);
        check("post_rst_en", rd, 48'h0);
        rdreg(3'd3, rd);
        check("post_rst_route", rd, 48'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
